mips_fetch_stage: RTL and testbench



---
 rtl/mips_fetch_stage_if.sv | 25 ++
 rtl/mips_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_mips_fetch_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface mips_fetch_stage_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ready;
  logic [INSTR_W-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ready,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ready,
    output rdata
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// Pipelined MIPS instruction-fetch stage: PC register, boot delay, IF/ID register.
// Optional perf counters (fetch_cnt_o / bubble_cnt_o) when MIPS_FETCH_PERF_EN is defined.
module mips_fetch_stage #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned INSTR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               redirect_valid_i,
  input  logic [ADDR_W-1:0]  redirect_pc_i,
  mips_fetch_stage_if.master imem,
  output logic               ifid_valid_o,
  output logic [ADDR_W-1:0]  ifid_pc_o,
  output logic [ADDR_W-1:0]  ifid_pc4_o,
  output logic [INSTR_W-1:0] ifid_instr_o,
  output logic               misalign_o
`ifdef MIPS_FETCH_PERF_EN
  ,
  output logic [31:0]        fetch_cnt_o,
  output logic [31:0]        bubble_cnt_o
`endif
);

  typedef enum logic {
    ST_BOOT,
    ST_FETCH
  } state_e;

  localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES);

  state_e             state_q,      state_d;
  logic [3:0]         boot_cnt_q,   boot_cnt_d;
  logic [ADDR_W-1:0]  pc_q,         pc_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic [ADDR_W-1:0]  ifid_pc_q,    ifid_pc_d;
  logic [ADDR_W-1:0]  ifid_pc4_q,   ifid_pc4_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic               misalign_q,   misalign_d;

  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  redirect_aligned;
  logic               capture;
  logic               bubble;

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0]        fetch_cnt_q,  fetch_cnt_d;
  logic [31:0]        bubble_cnt_q, bubble_cnt_d;
`endif

  assign pc_plus4         = pc_q + ADDR_W'(4);
  assign redirect_aligned = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d      = state_q;
    boot_cnt_d   = boot_cnt_q;
    pc_d         = pc_q;
    ifid_valid_d = ifid_valid_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_instr_d = ifid_instr_q;
    misalign_d   = misalign_q;
    capture      = 1'b0;
    bubble       = 1'b0;

    // Redirect target and sticky misalign flag apply in both states.
    if (redirect_valid_i) begin
      pc_d = redirect_aligned;
      if (redirect_pc_i[1:0] != 2'b00) begin
        misalign_d = 1'b1;
      end
    end

    unique case (state_q)
      ST_BOOT: begin
        if (boot_cnt_q <= 4'd1) begin
          state_d = ST_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q - 4'd1;
        end
      end

      ST_FETCH: begin
        if (redirect_valid_i || flush_i) begin
          ifid_valid_d = 1'b0;
          bubble       = 1'b1;
        end else if (stall_i) begin
          // Hold everything; a response arriving under stall is ignored.
        end else if (imem.ready) begin
          ifid_instr_d = imem.rdata;
          ifid_pc_d    = pc_q;
          ifid_pc4_d   = pc_plus4;
          ifid_valid_d = 1'b1;
          pc_d         = pc_plus4;
          capture      = 1'b1;
        end else begin
          ifid_valid_d = 1'b0;
          bubble       = 1'b1;
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

`ifdef MIPS_FETCH_PERF_EN
  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (capture && (fetch_cnt_q != '1)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = capture ^ bubble;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_BOOT;
      boot_cnt_q   <= BOOT_INIT;
      pc_q         <= RESET_PC;
      ifid_valid_q <= 1'b0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      boot_cnt_q   <= boot_cnt_d;
      pc_q         <= pc_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_instr_q <= ifid_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem.req     = (state_q == ST_FETCH) && !stall_i;
  assign imem.addr    = pc_q;
  assign ifid_valid_o = ifid_valid_q;
  assign ifid_pc_o    = ifid_pc_q;
  assign ifid_pc4_o   = ifid_pc4_q;
  assign ifid_instr_o = ifid_instr_q;
  assign misalign_o   = misalign_q;

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed self-checking bench for mips_fetch_stage: a 32-bit instance (boot, wait,
// stall, redirect, misalign, flush, reset) and an 8-bit instance (PC wrap).
module tb_mips_fetch_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- instance A: 32-bit, RESET_PC=0x100, BOOT_CYCLES=2
  logic        a_rst_n, a_stall, a_flush, a_redir;
  logic [31:0] a_redir_pc;
  logic        a_valid, a_misalign;
  logic [31:0] a_pc, a_pc4, a_instr;

  mips_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus_a ();
  assign bus_a.rdata = {16'hC0DE, bus_a.addr[15:0]};

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] a_fcnt, a_bcnt;
`endif

  mips_fetch_stage #(
    .ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h100), .BOOT_CYCLES(2)
  ) dut_a (
    .clk(clk), .rst_n(a_rst_n), .stall_i(a_stall), .flush_i(a_flush),
    .redirect_valid_i(a_redir), .redirect_pc_i(a_redir_pc), .imem(bus_a.master),
    .ifid_valid_o(a_valid), .ifid_pc_o(a_pc), .ifid_pc4_o(a_pc4),
    .ifid_instr_o(a_instr), .misalign_o(a_misalign)
`ifdef MIPS_FETCH_PERF_EN
    , .fetch_cnt_o(a_fcnt), .bubble_cnt_o(a_bcnt)
`endif
  );

  // ---------------- instance B: 8-bit address, RESET_PC=0, BOOT_CYCLES=1
  logic       b_rst_n, b_redir;
  logic [7:0] b_redir_pc;
  logic       b_valid, b_misalign;
  logic [7:0] b_pc, b_pc4;
  logic [31:0] b_instr;

  mips_fetch_stage_if #(.ADDR_W(8), .INSTR_W(32)) bus_b ();
  assign bus_b.rdata = {24'hC0DE00, bus_b.addr};
  assign bus_b.ready = 1'b1;

`ifdef MIPS_FETCH_PERF_EN
  logic [31:0] b_fcnt, b_bcnt;
`endif

  mips_fetch_stage #(
    .ADDR_W(8), .INSTR_W(32), .RESET_PC(8'h00), .BOOT_CYCLES(1)
  ) dut_b (
    .clk(clk), .rst_n(b_rst_n), .stall_i(1'b0), .flush_i(1'b0),
    .redirect_valid_i(b_redir), .redirect_pc_i(b_redir_pc), .imem(bus_b.master),
    .ifid_valid_o(b_valid), .ifid_pc_o(b_pc), .ifid_pc4_o(b_pc4),
    .ifid_instr_o(b_instr), .misalign_o(b_misalign)
`ifdef MIPS_FETCH_PERF_EN
    , .fetch_cnt_o(b_fcnt), .bubble_cnt_o(b_bcnt)
`endif
  );

  initial begin
    a_rst_n = 1'b0; a_stall = 1'b0; a_flush = 1'b0; a_redir = 1'b0; a_redir_pc = '0;
    bus_a.ready = 1'b1;
    b_rst_n = 1'b0; b_redir = 1'b0; b_redir_pc = '0;

    repeat (2) tick();
    check("rst_req",      bus_a.req, 0);
    check("rst_addr",     bus_a.addr, 64'h100);
    check("rst_valid",    a_valid, 0);
    check("rst_pc",       a_pc, 0);
    check("rst_pc4",      a_pc4, 0);
    check("rst_instr",    a_instr, 0);
    check("rst_misalign", a_misalign, 0);

    // Boot: request rises on the 2nd edge after release.
    a_rst_n = 1'b1;
    tick();
    check("boot_e1_req", bus_a.req, 0);
    tick();
    check("boot_e2_req",   bus_a.req, 1);
    check("boot_e2_valid", a_valid, 0);
    tick();
    check("f0_valid", a_valid, 1);
    check("f0_pc",    a_pc, 64'h100);
    check("f0_pc4",   a_pc4, 64'h104);
    check("f0_instr", a_instr, 64'hC0DE0100);
    tick();
    check("f1_pc",  a_pc, 64'h104);
    check("f1_pc4", a_pc4, 64'h108);
    tick();
    check("f2_pc",   a_pc, 64'h108);
    check("f2_pc4",  a_pc4, 64'h10C);
    check("f2_addr", bus_a.addr, 64'h10C);

    // Memory wait at 0x20.
    a_redir = 1'b1; a_redir_pc = 32'h20;
    tick();
    check("w_redir_valid", a_valid, 0);
    check("w_redir_addr",  bus_a.addr, 64'h20);
    a_redir = 1'b0; bus_a.ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("wait_valid", a_valid, 0);
      check("wait_addr",  bus_a.addr, 64'h20);
    end
    bus_a.ready = 1'b1;
    tick();
    check("wait_cap_valid", a_valid, 1);
    check("wait_cap_pc",    a_pc, 64'h20);
    check("wait_cap_instr", a_instr, 64'hC0DE0020);
    check("wait_cap_addr",  bus_a.addr, 64'h24);

    // Stall while IF/ID holds 0x40.
    a_redir = 1'b1; a_redir_pc = 32'h40;
    tick();
    a_redir = 1'b0;
    tick();
    check("st_pre_pc", a_pc, 64'h40);
    a_stall = 1'b1;
    #1;
    check("st_req", bus_a.req, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("st_valid", a_valid, 1);
      check("st_pc",    a_pc, 64'h40);
      check("st_instr", a_instr, 64'hC0DE0040);
      check("st_addr",  bus_a.addr, 64'h44);
    end
    a_stall = 1'b0;
    tick();
    check("st_resume_pc", a_pc, 64'h44);

    // Redirect with stall: redirect wins.
    a_redir = 1'b1; a_redir_pc = 32'h200; a_stall = 1'b1;
    tick();
    check("rs_valid", a_valid, 0);
    check("rs_addr",  bus_a.addr, 64'h200);
    a_redir = 1'b0; a_stall = 1'b0;
    tick();
    check("rs_cap_valid", a_valid, 1);
    check("rs_cap_pc",    a_pc, 64'h200);

    // Misaligned redirect.
    check("mis_pre", a_misalign, 0);
    a_redir = 1'b1; a_redir_pc = 32'h302;
    tick();
    check("mis_addr", bus_a.addr, 64'h300);
    check("mis_flag", a_misalign, 1);
    a_redir = 1'b0;
    tick();
    check("mis_cap_pc", a_pc, 64'h300);
    tick();
    check("mis_cap2_pc", a_pc, 64'h304);
    check("mis_sticky",  a_misalign, 1);

    // Flush alone: kills IF/ID, PC untouched.
    a_flush = 1'b1;
    tick();
    check("fl_valid", a_valid, 0);
    check("fl_addr",  bus_a.addr, 64'h308);
    a_flush = 1'b0;
    tick();
    check("fl_cap_pc", a_pc, 64'h308);

    // Reset in the middle of a memory wait.
    bus_a.ready = 1'b0;
    tick();
    a_rst_n = 1'b0;
    #1;
    check("mr_req",      bus_a.req, 0);
    check("mr_addr",     bus_a.addr, 64'h100);
    check("mr_valid",    a_valid, 0);
    check("mr_misalign", a_misalign, 0);
    bus_a.ready = 1'b1;
    tick();
    check("mr_hold_valid", a_valid, 0);

    // Wrap on the 8-bit instance.
    b_rst_n = 1'b1;
    tick();
    check("b_boot_req", bus_b.req, 1);
    b_redir = 1'b1; b_redir_pc = 8'hFC;
    tick();
    check("b_redir_addr",  bus_b.addr, 64'hFC);
    check("b_redir_valid", b_valid, 0);
    b_redir = 1'b0;
    tick();
    check("b_wrap_pc",    b_pc, 64'hFC);
    check("b_wrap_pc4",   b_pc4, 64'h00);
    check("b_wrap_instr", b_instr, 64'hC0DE00FC);
    check("b_wrap_addr",  bus_b.addr, 64'h00);
`ifdef MIPS_FETCH_PERF_EN
    check("b_fcnt1", b_fcnt, 1);
`endif
    tick();
    check("b_next_pc",  b_pc, 64'h00);
    check("b_next_pc4", b_pc4, 64'h04);
    check("b_misalign", b_misalign, 0);
`ifdef MIPS_FETCH_PERF_EN
    check("b_fcnt2", b_fcnt, 2);
    check("b_bcnt",  b_bcnt, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
